// File: rtl/cmp_minmax_seq.sv
// cmp_minmax_seq: finds the unsigned maximum and minimum of a burst of samples
// using one shared magnitude comparator, time-multiplexed between the running
// max (CMP_MAX) and the running min (CMP_MIN).
// Optional feature macro: CMP_IDX_EN adds max_idx/min_idx (burst position of
// each retained extreme).
module cmp_minmax_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val
`ifdef CMP_IDX_EN
   ,output logic [LEN_W-1:0]  max_idx,
    output logic [LEN_W-1:0]  min_idx
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCEPT  = 3'd1;
    localparam logic [2:0] S_CMP_MAX = 3'd2;
    localparam logic [2:0] S_CMP_MIN = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count_q;
    logic              first_q;
    logic [DATA_W-1:0] sample_q;

    logic              start_acc;
    logic              take_sample;
    logic              upd_max;
    logic              upd_min;
    logic              step;

    logic [DATA_W-1:0] cmp_b_c;
    logic              cmp_gt_c;
    logic              cmp_lt_c;

    // Shared comparator: operand b follows the phase (max first, then min)
    always_comb begin
        cmp_b_c  = (state_q == S_CMP_MAX) ? max_val : min_val;
        cmp_gt_c = (sample_q > cmp_b_c);
        cmp_lt_c = (sample_q < cmp_b_c);
    end

    // Next-state and datapath enables; abort overrides everything
    always_comb begin
        state_d     = state_q;
        start_acc   = 1'b0;
        take_sample = 1'b0;
        upd_max     = 1'b0;
        upd_min     = 1'b0;
        step        = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (len != '0)) begin
                        start_acc = 1'b1;
                        state_d   = S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        take_sample = 1'b1;
                        state_d     = S_CMP_MAX;
                    end
                end
                S_CMP_MAX: begin
                    upd_max = first_q || cmp_gt_c;
                    state_d = S_CMP_MIN;
                end
                S_CMP_MIN: begin
                    upd_min = first_q || cmp_lt_c;
                    step    = 1'b1;
                    state_d = (count_q == (len_q - LEN_W'(1))) ? S_DONE : S_ACCEPT;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered status outputs decoded from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d == S_ACCEPT);
            busy      <= (state_d != S_IDLE);
            out_valid <= (state_d == S_DONE);
        end
    end

    // Burst bookkeeping and running extremes (ties never update)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            count_q  <= '0;
            first_q  <= 1'b0;
            sample_q <= '0;
            max_val  <= '0;
            min_val  <= '1;
`ifdef CMP_IDX_EN
            max_idx  <= '0;
            min_idx  <= '0;
`endif
        end else begin
            if (start_acc) begin
                len_q   <= len;
                count_q <= '0;
                first_q <= 1'b1;
            end
            if (take_sample) begin
                sample_q <= in_data;
            end
            if (upd_max) begin
                max_val <= sample_q;
`ifdef CMP_IDX_EN
                max_idx <= count_q;
`endif
            end
            if (upd_min) begin
                min_val <= sample_q;
`ifdef CMP_IDX_EN
                min_idx <= count_q;
`endif
            end
            if (step) begin
                count_q <= count_q + LEN_W'(1);
                first_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Testbench for cmp_minmax_seq: directed scenarios plus random bursts; expected
// results are computed from the sample list and checked by a separate monitor.
module tb_cmp_minmax_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] max_val;
    logic [7:0] min_val;
`ifdef CMP_IDX_EN
    logic [7:0] max_idx;
    logic [7:0] min_idx;
`endif

    cmp_minmax_seq #(.DATA_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .max_val(max_val), .min_val(min_val)
`ifdef CMP_IDX_EN
       ,.max_idx(max_idx), .min_idx(min_idx)
`endif
    );

    typedef struct {
        logic [7:0] mx;
        logic [7:0] mn;
        logic [7:0] mxi;
        logic [7:0] mni;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] smp[$];
    int         total = 0;
    int         bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: extremes of a list, strict comparison so the first occurrence wins
    function automatic exp_t model(input int n);
        exp_t e;
        e.mx = smp[0]; e.mn = smp[0]; e.mxi = 8'd0; e.mni = 8'd0;
        for (int i = 1; i < n; i++) begin
            if (smp[i] > e.mx) begin e.mx = smp[i]; e.mxi = 8'(i); end
            if (smp[i] < e.mn) begin e.mn = smp[i]; e.mni = 8'(i); end
        end
        return e;
    endfunction

    // Monitor: pops one expectation per accepted result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(out_valid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_max", 32'(max_val), 32'(e.mx));
                    chk("sb_min", 32'(min_val), 32'(e.mn));
`ifdef CMP_IDX_EN
                    chk("sb_max_idx", 32'(max_idx), 32'(e.mxi));
                    chk("sb_min_idx", 32'(min_idx), 32'(e.mni));
`endif
                end
            end
        end
    end

    task automatic do_start(input int n);
        int w = 0;
        while (busy && w < 50) begin tick(); w++; end
        if (w >= 50) chk("start_wait_timeout", 32'(busy), 32'(0));
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'(1));
        chk("start_in_ready", 32'(in_ready), 32'(1));
    endtask

    // Waits for in_ready, hands one sample over; junk keeps in_valid high
    // through the compare cycles with a misleading value
    task automatic send_sample(input logic [7:0] d, input bit junk);
        int w = 0;
        while (!in_ready && w < 50) begin tick(); w++; end
        if (w >= 50) chk("in_ready_timeout", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_data  = d;
        tick();
        if (junk) begin
            in_data = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            chk("cmp_in_ready_lo", 32'(in_ready), 32'(0));
            tick();
            chk("cmp2_in_ready_lo", 32'(in_ready), 32'(0));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_burst(input int hold, input bit junk, input bit busy_start);
        exp_t e;
        int   n = smp.size();
        out_ready = (hold == 0);
        do_start(n);
        if (busy_start) begin
            start = 1'b1;
            len   = 8'd5;
        end
        for (int i = 0; i < n; i++) begin
            send_sample(smp[i], junk && (i != n - 1));
            start = 1'b0;
        end
        e = model(n);
        exp_q.push_back(e);
        chk("lat0_out_valid", 32'(out_valid), 32'(0));
        tick();
        chk("lat1_out_valid", 32'(out_valid), 32'(0));
        tick();
        chk("lat2_out_valid", 32'(out_valid), 32'(1));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'(1));
            chk("hold_max", 32'(max_val), 32'(e.mx));
            chk("hold_min", 32'(min_val), 32'(e.mn));
        end
        out_ready = 1'b1;
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_max", 32'(max_val), 32'h00);
        chk("rst_min", 32'(min_val), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        smp = '{8'h10, 8'h80, 8'h03, 8'h7F};
        run_burst(0, 1'b0, 1'b0);
        smp = '{8'h55, 8'h55, 8'h55};
        run_burst(0, 1'b1, 1'b0);
        smp = '{8'h00};
        run_burst(5, 1'b0, 1'b0);

        // abort after 2 of 4 samples, offered together with a handshake
        smp = '{8'h20, 8'h90, 8'h44, 8'h05};
        do_start(4);
        send_sample(smp[0], 1'b0);
        send_sample(smp[1], 1'b0);
        begin
            int w = 0;
            while (!in_ready && w < 50) begin tick(); w++; end
        end
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h01;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_in_ready", 32'(in_ready), 32'(0));
        chk("abort_max_kept", 32'(max_val), 32'h90);
        chk("abort_min_kept", 32'(min_val), 32'h20);
        repeat (4) begin
            tick();
            chk("abort_no_out_valid", 32'(out_valid), 32'(0));
        end
        smp = '{8'hFF, 8'h01};
        run_burst(0, 1'b0, 1'b0);

        // start with len==0 is ignored; values stay from the previous burst
        start = 1'b1; len = 8'd0; in_valid = 1'b1; in_data = 8'h77;
        tick(); tick();
        start = 1'b0; in_valid = 1'b0;
        chk("len0_busy", 32'(busy), 32'(0));
        chk("len0_in_ready", 32'(in_ready), 32'(0));
        chk("len0_max", 32'(max_val), 32'hFF);
        chk("len0_min", 32'(min_val), 32'h01);

        // start held while busy must not recapture len
        smp = '{8'h3C, 8'hC3};
        run_burst(0, 1'b0, 1'b1);

        for (int b = 0; b < 20; b++) begin
            int n = $urandom_range(1, 10);
            smp.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 5))
                    0: smp.push_back(8'h00);
                    1: smp.push_back(8'hFF);
                    2: smp.push_back(8'h80);
                    default: smp.push_back(8'($urandom));
                endcase
            end
            run_burst($urandom_range(0, 3), $urandom_range(0, 1) != 0, 1'b0);
        end

        // async reset mid-burst: no partial result
        smp = '{8'h33, 8'h44, 8'h22};
        do_start(3);
        send_sample(smp[0], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_in_ready", 32'(in_ready), 32'(0));
        chk("arst_out_valid", 32'(out_valid), 32'(0));
        chk("arst_max", 32'(max_val), 32'h00);
        chk("arst_min", 32'(min_val), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("arst_no_out_valid", 32'(out_valid), 32'(0));
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
